switch_debouncer: RTL and testbench

//   Conditions raw slide-switch inputs before they reach the comparator core
//   (a = sw[0], b = sw[1]).
//   - Per channel: two-flop synchroniser, then a counter-based debounce filter.
//   - Outputs are a clean, glitch-free level, plus one-cycle rise/fall pulses.
//   - Sits between the board switch pins and the comparator.

---
 rtl/switch_debouncer.sv | 59 +++++
 tb/tb_switch_debouncer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel two-flop synchroniser plus counter debounce with rise/fall pulses
// Ports: clk (rising edge), rst_n (sync, active-low), sw_in[WIDTH] raw switches,
//        sw_db[WIDTH] debounced level, sw_rise/sw_fall[WIDTH] one-cycle edge pulses.
module switch_debouncer #(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1_q, s2_q, db_q, db_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  // A mismatch between s2 and the accepted level counts up; any match aborts
  // the run, so the counter never passes CNT_MAX.
  always_comb begin
    db_d = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      s1_q <= sw_in;
      s2_q <= s1_q;
      db_q <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q <= cnt_d;
    end
  end
  assign sw_db = db_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus with a pulse-event scoreboard for switch_debouncer
module tb_switch_debouncer;
  localparam int W = 2;
  localparam int D = 4;
  typedef struct {
    int cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] db;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sw_in = 2'b11;
  logic [1:0] sw_db, sw_rise, sw_fall;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // dt edges from now the DUT must show this pulse; a level set just after
  // edge c is first sampled on c+1 and accepted on c+1+D+1 = c+6.
  task automatic ev(int dt, logic [1:0] r, logic [1:0] f, logic [1:0] d);
    sb.push_back('{cyc + dt, r, f, d});
  endtask
  always @(negedge clk) begin
    exp_t e;
    if ((sw_rise | sw_fall) != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {28'd0, sw_rise, sw_fall}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_rise", {30'd0, sw_rise}, {30'd0, e.rise});
        chk("pulse_fall", {30'd0, sw_fall}, {30'd0, e.fall});
        chk("pulse_db", {30'd0, sw_db}, {30'd0, e.db});
      end
    end
  end
  initial begin
    repeat (3) begin
      tick(1);
      chk("reset_db", {30'd0, sw_db}, 32'd0);
      chk("reset_pulses", {28'd0, sw_rise, sw_fall}, 32'd0);
    end
    ev(6, 2'b11, 2'b00, 2'b11);
    rst_n = 1'b1;
    tick(5);
    chk("t1_pre_db", {30'd0, sw_db}, 32'd0);
    tick(1);
    chk("t1_db", {30'd0, sw_db}, 32'd3);
    tick(2);
    sw_in = 2'b00;
    ev(6, 2'b00, 2'b11, 2'b00);
    tick(8);
    sw_in = 2'b01;
    ev(6, 2'b01, 2'b00, 2'b01);
    tick(5);
    chk("t2_pre_db", {30'd0, sw_db}, 32'd0);
    tick(1);
    chk("t2_db", {30'd0, sw_db}, 32'd1);
    tick(3);
    sw_in = 2'b00;
    ev(6, 2'b00, 2'b01, 2'b00);
    tick(8);
    sw_in = 2'b10;
    tick(3);
    sw_in = 2'b00;
    tick(8);
    chk("t3_short_db", {30'd0, sw_db}, 32'd0);
    sw_in = 2'b10;
    ev(6, 2'b10, 2'b00, 2'b10);
    tick(4);
    sw_in = 2'b00;
    ev(6, 2'b00, 2'b10, 2'b00);
    tick(10);
    sw_in = 2'b01;
    tick(1);
    sw_in = 2'b00;
    tick(1);
    sw_in = 2'b01;
    tick(2);
    sw_in = 2'b00;
    tick(1);
    sw_in = 2'b01;
    ev(6, 2'b01, 2'b00, 2'b01);
    tick(5);
    chk("t4_pre_db", {30'd0, sw_db}, 32'd0);
    tick(1);
    chk("t4_db", {30'd0, sw_db}, 32'd1);
    tick(3);
    sw_in = 2'b00;
    ev(6, 2'b00, 2'b01, 2'b00);
    tick(8);
    sw_in = 2'b01;
    ev(6, 2'b01, 2'b00, 2'b01);
    tick(2);
    sw_in = 2'b11;
    ev(6, 2'b10, 2'b00, 2'b11);
    tick(8);
    chk("t5_db", {30'd0, sw_db}, 32'd3);
    sw_in = 2'b00;
    ev(6, 2'b00, 2'b11, 2'b00);
    tick(8);
    sw_in = 2'b01;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("t6_reset_db", {30'd0, sw_db}, 32'd0);
    rst_n = 1'b1;
    ev(6, 2'b01, 2'b00, 2'b01);
    tick(5);
    chk("t6_pre_db", {30'd0, sw_db}, 32'd0);
    tick(1);
    chk("t6_db", {30'd0, sw_db}, 32'd1);
    tick(10);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
